mc_maindec: RTL and testbench

Multicycle MIPS main control FSM. It drives the aluop code consumed by the ALU function decoder, and all datapath enables and selects. Inputs are the 6-bit opcode from the instruction register plus a memory-ready handshake. It sits in the controller alongside the ALU function decoder and feeds the multicycle datapath.

---
 rtl/mips_ctrl_pkg.sv | 56 +++++
 rtl/mc_outdec.sv | 87 ++++++++
 rtl/mc_maindec.sv | 96 +++++++++
 tb/tb_mc_maindec.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: opcodes, ALU
// operation codes, FSM state encoding and the packed control word.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } statetype;

  // Every datapath enable/select driven by the main decoder, in one word.
  typedef struct packed {
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       illegal;
  } ctrl_t;

  // True for the opcodes this controller knows how to sequence.
  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_supported = 1'b1;
      default:                                      op_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_outdec.sv
// Combinational state-to-control-word decoder for the multicycle main FSM.
// Only FETCH (memory ready) and DECODE (illegal opcode) look past the state.
module mc_outdec
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] i_state,
  input  logic       i_memrdy,
  input  logic       i_op_bad,
  output ctrl_t      o_ctrl
);

  // Decode the registered state; unlisted fields and unused encodings stay 0.
  always_comb begin
    o_ctrl = '0;
    case (i_state)
      FETCH: begin
        o_ctrl.iord    = 1'b0;
        o_ctrl.alusrca = 1'b0;
        o_ctrl.alusrcb = 2'b01;
        o_ctrl.aluop   = ALUOP_ADD;
        o_ctrl.pcsrc   = 2'b00;
        // Instruction fetch and PC+4 commit only once memory delivers.
        o_ctrl.irwrite = i_memrdy;
        o_ctrl.pcwrite = i_memrdy;
      end
      DECODE: begin
        // Branch target precompute: PC + (signimm << 2).
        o_ctrl.alusrca = 1'b0;
        o_ctrl.alusrcb = 2'b11;
        o_ctrl.aluop   = ALUOP_ADD;
        o_ctrl.illegal = i_op_bad;
      end
      MEMADR: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = 2'b10;
        o_ctrl.aluop   = ALUOP_ADD;
      end
      MEMRD: begin
        o_ctrl.iord = 1'b1;
      end
      MEMWB: begin
        o_ctrl.regdst   = 1'b0;
        o_ctrl.memtoreg = 1'b1;
        o_ctrl.regwrite = 1'b1;
      end
      MEMWR: begin
        o_ctrl.iord     = 1'b1;
        o_ctrl.memwrite = 1'b1;
      end
      EXECUTE: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = 2'b00;
        o_ctrl.aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        o_ctrl.regdst   = 1'b1;
        o_ctrl.memtoreg = 1'b0;
        o_ctrl.regwrite = 1'b1;
      end
      BRANCH: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = 2'b00;
        o_ctrl.aluop   = ALUOP_SUB;
        o_ctrl.pcsrc   = 2'b01;
        o_ctrl.branch  = 1'b1;
      end
      ADDIEX: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = 2'b10;
        o_ctrl.aluop   = ALUOP_ADD;
      end
      ADDIWB: begin
        o_ctrl.regdst   = 1'b0;
        o_ctrl.memtoreg = 1'b0;
        o_ctrl.regwrite = 1'b1;
      end
      JUMP: begin
        o_ctrl.pcsrc   = 2'b10;
        o_ctrl.pcwrite = 1'b1;
      end
      default: begin
        o_ctrl = '0;
      end
    endcase
  end

endmodule

// File: rtl/mc_maindec.sv
// Multicycle MIPS main control FSM: state register and next-state logic,
// with control outputs decoded from the state by mc_outdec.
module mc_maindec
  import mips_ctrl_pkg::*;
#(
  parameter bit HAS_MEMREADY = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       memready,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       illegal,
  output logic [3:0] state_o
);

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic       w_memrdy;
  logic       w_op_bad;
  ctrl_t      w_ctrl;

  // Zero-wait memory builds tie the handshake high.
  assign w_memrdy = HAS_MEMREADY ? memready : 1'b1;
  assign w_op_bad = ~op_supported(op);

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_next;
  end

  // Next-state selection; unused encodings fall back to FETCH.
  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH:   w_next = w_memrdy ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_RTYPE:     w_next = EXECUTE;
          OP_BEQ:       w_next = BRANCH;
          OP_ADDI:      w_next = ADDIEX;
          OP_J:         w_next = JUMP;
          default:      w_next = FETCH;
        endcase
      end
      // The IR keeps op stable, so it still tells lw from sw here.
      MEMADR:  w_next = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   w_next = w_memrdy ? MEMWB : MEMRD;
      MEMWB:   w_next = FETCH;
      MEMWR:   w_next = w_memrdy ? FETCH : MEMWR;
      EXECUTE: w_next = ALUWB;
      ALUWB:   w_next = FETCH;
      BRANCH:  w_next = FETCH;
      ADDIEX:  w_next = ADDIWB;
      ADDIWB:  w_next = FETCH;
      JUMP:    w_next = FETCH;
      default: w_next = FETCH;
    endcase
  end

  mc_outdec u_outdec (
    .i_state  (r_state),
    .i_memrdy (w_memrdy),
    .i_op_bad (w_op_bad),
    .o_ctrl   (w_ctrl)
  );

  assign memwrite = w_ctrl.memwrite;
  assign iord     = w_ctrl.iord;
  assign irwrite  = w_ctrl.irwrite;
  assign pcwrite  = w_ctrl.pcwrite;
  assign branch   = w_ctrl.branch;
  assign alusrca  = w_ctrl.alusrca;
  assign alusrcb  = w_ctrl.alusrcb;
  assign regdst   = w_ctrl.regdst;
  assign memtoreg = w_ctrl.memtoreg;
  assign regwrite = w_ctrl.regwrite;
  assign pcsrc    = w_ctrl.pcsrc;
  assign aluop    = w_ctrl.aluop;
  assign illegal  = w_ctrl.illegal;
  assign state_o  = r_state;

endmodule

// File: tb/tb_mc_maindec.sv
// Self-checking bench for mc_maindec: instructions are expanded into their
// per-cycle phase sequence, expected control words are queued per cycle,
// and a negedge monitor compares them against the DUT.
module tb_mc_maindec;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       memready;
  logic       memwrite, iord, irwrite, pcwrite, branch, alusrca;
  logic [1:0] alusrcb;
  logic       regdst, memtoreg, regwrite;
  logic [1:0] pcsrc, aluop;
  logic       illegal;
  logic [3:0] state_o;

  mc_maindec #(.HAS_MEMREADY(1'b1)) dut (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .memready (memready),
    .memwrite (memwrite),
    .iord     (iord),
    .irwrite  (irwrite),
    .pcwrite  (pcwrite),
    .branch   (branch),
    .alusrca  (alusrca),
    .alusrcb  (alusrcb),
    .regdst   (regdst),
    .memtoreg (memtoreg),
    .regwrite (regwrite),
    .pcsrc    (pcsrc),
    .aluop    (aluop),
    .illegal  (illegal),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    statetype    st;
    logic [15:0] w;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [5:0] T_LW = 6'b100011, T_SW = 6'b101011, T_R = 6'b000000;
  localparam logic [5:0] T_BEQ = 6'b000100, T_ADDI = 6'b001000, T_J = 6'b000010;

  wire [15:0] act = {memwrite, iord, irwrite, pcwrite, branch, alusrca, alusrcb,
                     regdst, memtoreg, regwrite, pcsrc, aluop, illegal};

  // Expected control word for a phase, straight from the output table.
  function automatic logic [15:0] exp_word(statetype ph, logic mr, logic ill);
    logic mw, io, irw, pcw, br, asa, rd, m2r, rw, il;
    logic [1:0] asb, pcs, aop;
    {mw, io, irw, pcw, br, asa, rd, m2r, rw, il} = '0;
    asb = 2'b00; pcs = 2'b00; aop = 2'b00;
    case (ph)
      FETCH:   begin asb = 2'b01; irw = mr; pcw = mr; end
      DECODE:  begin asb = 2'b11; il = ill; end
      MEMADR:  begin asa = 1'b1; asb = 2'b10; end
      MEMRD:   begin io = 1'b1; end
      MEMWB:   begin m2r = 1'b1; rw = 1'b1; end
      MEMWR:   begin io = 1'b1; mw = 1'b1; end
      EXECUTE: begin asa = 1'b1; aop = 2'b10; end
      ALUWB:   begin rd = 1'b1; rw = 1'b1; end
      BRANCH:  begin asa = 1'b1; aop = 2'b01; pcs = 2'b01; br = 1'b1; end
      ADDIEX:  begin asa = 1'b1; asb = 2'b10; end
      ADDIWB:  begin rw = 1'b1; end
      JUMP:    begin pcs = 2'b10; pcw = 1'b1; end
      default: ;
    endcase
    return {mw, io, irw, pcw, br, asa, asb, rd, m2r, rw, pcs, aop, il};
  endfunction

  // One clock: drive inputs, queue the expected response, advance.
  task automatic cyc(input statetype ph, input logic mr, input logic rs, input logic ill);
    exp_t e;
    memready = mr;
    reset    = rs;
    e.st = ph;
    e.w  = exp_word(ph, mr, ill);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(1, 0));
  endfunction

  // Expand one instruction into its cycles, with optional stalls and a
  // reset landing in the data-read wait.
  task automatic do_instr(input logic [5:0] opc, input int fstall, input int mstall,
                          input bit rst_mid);
    logic ill;
    op  = opc;
    ill = !(opc inside {T_LW, T_SW, T_R, T_BEQ, T_ADDI, T_J});
    repeat (fstall) cyc(FETCH, 1'b0, 1'b0, 1'b0);
    cyc(FETCH, 1'b1, 1'b0, 1'b0);
    cyc(DECODE, rbit(), 1'b0, ill);
    if (ill) return;
    case (opc)
      T_LW: begin
        cyc(MEMADR, rbit(), 1'b0, 1'b0);
        repeat (mstall) cyc(MEMRD, 1'b0, 1'b0, 1'b0);
        if (rst_mid) begin
          cyc(MEMRD, 1'b1, 1'b1, 1'b0);
          return;
        end
        cyc(MEMRD, 1'b1, 1'b0, 1'b0);
        cyc(MEMWB, rbit(), 1'b0, 1'b0);
      end
      T_SW: begin
        cyc(MEMADR, rbit(), 1'b0, 1'b0);
        repeat (mstall) cyc(MEMWR, 1'b0, 1'b0, 1'b0);
        cyc(MEMWR, 1'b1, 1'b0, 1'b0);
      end
      T_R: begin
        cyc(EXECUTE, rbit(), 1'b0, 1'b0);
        cyc(ALUWB, rbit(), 1'b0, 1'b0);
      end
      T_BEQ:  cyc(BRANCH, rbit(), 1'b0, 1'b0);
      T_ADDI: begin
        cyc(ADDIEX, rbit(), 1'b0, 1'b0);
        cyc(ADDIWB, rbit(), 1'b0, 1'b0);
      end
      T_J:    cyc(JUMP, rbit(), 1'b0, 1'b0);
      default: ;
    endcase
  endtask

  // Monitor: every cycle the DUT presents a control word and a state.
  always @(negedge clk) begin
    exp_t e;
    int   nwr;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({state_o, act} !== {4'(e.st), e.w}) begin
        errors++;
        $display("FAIL cycle_word t=%0t got state=%0d word=%b expected state=%0d word=%b",
                 $time, state_o, act, 4'(e.st), e.w);
      end
      nwr = int'(regwrite) + int'(memwrite) + int'(pcwrite) + int'(irwrite);
      checks++;
      if (nwr > 1 && !(pcwrite && irwrite && nwr == 2)) begin
        errors++;
        $display("FAIL write_exclusive t=%0t got rw=%b mw=%b pcw=%b irw=%b expected at most one (or pcw+irw)",
                 $time, regwrite, memwrite, pcwrite, irwrite);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] opc;
    int         pick;
    reset    = 1'b1;
    memready = 1'b1;
    op       = 6'b000000;
    @(posedge clk);
    #1;
    cyc(FETCH, 1'b1, 1'b1, 1'b0);

    do_instr(T_LW,   0, 0, 1'b0);
    do_instr(T_R,    0, 0, 1'b0);
    do_instr(T_BEQ,  0, 0, 1'b0);
    do_instr(T_J,    0, 0, 1'b0);
    do_instr(T_SW,   0, 3, 1'b0);
    do_instr(T_SW,   3, 0, 1'b0);
    do_instr(T_ADDI, 0, 0, 1'b0);
    do_instr(6'b111111, 0, 0, 1'b0);
    do_instr(T_LW,   0, 2, 1'b1);
    do_instr(T_R,    1, 0, 1'b0);

    repeat (300) begin
      pick = $urandom_range(6, 0);
      case (pick)
        0: opc = T_LW;
        1: opc = T_SW;
        2: opc = T_R;
        3: opc = T_BEQ;
        4: opc = T_ADDI;
        5: opc = T_J;
        default: opc = 6'($urandom_range(63, 0));
      endcase
      do_instr(opc, ($urandom_range(3, 0) == 0) ? $urandom_range(3, 1) : 0,
               ($urandom_range(2, 0) == 0) ? $urandom_range(3, 1) : 0,
               ($urandom_range(9, 0) == 0));
    end

    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
